// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Window is 0x24A..0x1249; the responder sees window-relative offsets.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [31:0] WIN_BASE  = 32'h24A;
  localparam logic [31:0] WIN_LIMIT = 32'h1249;
  localparam logic [31:0] WIN_SIZE  = 32'h1000;

  localparam int DEPTH_DEFAULT = 1024;
  localparam int LANES         = 4;

endpackage

// File: rtl/dmem_if.sv
// Data-bus handshake between the address decoder and the responder.
// Master is the decoder side, slave is the memory side.
interface dmem_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic              cs;
  logic              iWE;
  logic [ADDR_W-1:0] iAddress;
  logic [31:0]       wdata;
  logic [LANES-1:0]  byte_en;
  logic [31:0]       rdata;
  logic              ready;
  logic              err;

  modport master (
    output cs, iWE, iAddress, wdata, byte_en,
    input  rdata, ready, err
  );

  modport slave (
    input  cs, iWE, iAddress, wdata, byte_en,
    output rdata, ready, err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with byte-lane writes and a registered read port.
// q clears on reset or on clr; RAM contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic             clr,
  input  logic [LANES-1:0] be,
  input  logic [AW-1:0]    addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      q
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (re) begin
      q <= mem[addr];
    end else if (clr) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: accepts a request in IDLE, waits WAIT_STATES
// cycles, then pulses ready for one cycle with rdata/err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT =
    ADDR_W'(DEPTH * LANES);
  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t          state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic            we_q, oor_q;
  logic [AW-1:0]   idx_q;
  logic            accept, oor_live;
  logic            cur_we, cur_oor;
  logic            enter_resp;
  logic            ram_we, ram_re, ram_clr;
  logic [AW-1:0]   ram_addr;

  // Byte-offset compare is equivalent to word index >= DEPTH.
  assign oor_live = bus.iAddress >= LIMIT;
  assign accept   = (state == IDLE) && bus.cs;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cs) begin
          if (WAIT_STATES == 0) begin
            state_nx   = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With zero wait states the read happens on the acceptance edge.
  assign cur_we   = (state == IDLE) ? bus.iWE : we_q;
  assign cur_oor  = (state == IDLE) ? oor_live : oor_q;
  assign ram_addr = (state == IDLE) ? bus.iAddress[AW+1:2] : idx_q;
  assign ram_we   = accept & bus.iWE & ~oor_live;
  assign ram_re   = enter_resp & ~cur_we & ~cur_oor;
  assign ram_clr  = enter_resp & cur_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      we_q  <= 1'b0;
      oor_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        we_q  <= bus.iWE;
        oor_q <= oor_live;
        idx_q <= bus.iAddress[AW+1:2];
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .clr   (ram_clr),
    .be    (bus.byte_en),
    .addr  (ram_addr),
    .wdata (bus.wdata),
    .q     (bus.rdata)
  );

  assign bus.ready = (state == RESP);
  assign bus.err   = (state == RESP) & oor_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with one and zero wait states.
// Two instances share clock and reset.
module tb_dmem_responder;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dmem_if #(.ADDR_W(32)) b0 ();
  dmem_if #(.ADDR_W(32)) b1 ();

  dmem_responder #(
    .DEPTH       (1024),
    .WAIT_STATES (1),
    .ADDR_W      (32)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  dmem_responder #(
    .DEPTH       (1024),
    .WAIT_STATES (0),
    .ADDR_W      (32)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One request on the one-wait-state instance; inputs are scrambled
  // after acceptance so only captured values may matter.
  task automatic req1(
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  be,
    output logic [31:0] rd,
    output logic        er,
    output int          lat
  );
    @(negedge clk);
    b1.cs       = 1'b1;
    b1.iWE      = we;
    b1.iAddress = a;
    b1.wdata    = d;
    b1.byte_en  = be;
    @(posedge clk);
    #1;
    b1.cs       = 1'b0;
    b1.iWE      = ~we;
    b1.iAddress = 32'h0;
    b1.wdata    = 32'h0;
    b1.byte_en  = 4'h0;
    lat = 0;
    while (!b1.ready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = b1.rdata;
    er = b1.err;
    @(posedge clk);
    #1;
    chk("ready_drop", {31'b0, b1.ready}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        prev;

  initial begin
    rst = 1'b1;
    b0.cs = 1'b0; b0.iWE = 1'b0; b0.iAddress = '0;
    b0.wdata = '0; b0.byte_en = '0;
    b1.cs = 1'b0; b1.iWE = 1'b0; b1.iAddress = '0;
    b1.wdata = '0; b1.byte_en = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, b1.ready}, 32'd0);
    chk("rst_err", {31'b0, b1.err}, 32'd0);
    chk("rst_rdata", b1.rdata, 32'd0);
    chk("rst_ready0", {31'b0, b0.ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    req1(1'b1, 32'h010, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("wr_lat", lat, 32'd1);
    chk("wr_err", {31'b0, er}, 32'd0);
    chk("wr_rdata_hold", rd, 32'd0);
    req1(1'b0, 32'h010, 32'h0, 4'h0, rd, er, lat);
    chk("rd_lat", lat, 32'd1);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", {31'b0, er}, 32'd0);

    req1(1'b1, 32'h020, 32'h11223344, 4'hF, rd, er, lat);
    req1(1'b1, 32'h020, 32'hAABBCCDD, 4'h5, rd, er, lat);
    req1(1'b0, 32'h020, 32'h0, 4'hF, rd, er, lat);
    chk("partial_wr", rd, 32'h11BB33DD);

    req1(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
    chk("oor_rd_err", {31'b0, er}, 32'd1);
    chk("oor_rd_data", rd, 32'd0);
    chk("oor_rd_lat", lat, 32'd1);

    req1(1'b1, 32'h000, 32'h01010101, 4'hF, rd, er, lat);
    req1(1'b1, 32'h004, 32'h02020202, 4'hF, rd, er, lat);
    req1(1'b1, 32'hFFC, 32'hFEFEFEFE, 4'hF, rd, er, lat);
    req1(1'b1, 32'h1004, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    chk("oor_wr_err", {31'b0, er}, 32'd1);
    req1(1'b0, 32'h000, 32'h0, 4'h0, rd, er, lat);
    chk("oor_wr_w0", rd, 32'h01010101);
    req1(1'b0, 32'h004, 32'h0, 4'h0, rd, er, lat);
    chk("oor_wr_w1", rd, 32'h02020202);
    req1(1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
    chk("oor_wr_w1023", rd, 32'hFEFEFEFE);
    chk("w1023_err", {31'b0, er}, 32'd0);

    req1(1'b1, 32'h0C4, 32'h0BADF00D, 4'hF, rd, er, lat);
    req1(1'b0, 32'h0C7, 32'h0, 4'h0, rd, er, lat);
    chk("offset_rd", rd, 32'h0BADF00D);
    chk("offset_err", {31'b0, er}, 32'd0);

    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b0.cs       = 1'b1;
      b0.iWE      = (i < 2) || (i >= 4);
      b0.iAddress = 32'h3FC;
      b0.wdata    = (i < 2) ? 32'hCAFE0001 : 32'h5A5AA5A5;
      b0.byte_en  = 4'hF;
      @(posedge clk);
      #1;
      chk("w0_ready", {31'b0, b0.ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("w0_b2b", {31'b0, b0.ready & prev}, 32'd0);
      prev = b0.ready;
      if (i == 2) chk("w0_rd", b0.rdata, 32'hCAFE0001);
      if (i == 4) chk("w0_hold", b0.rdata, 32'hCAFE0001);
    end
    @(negedge clk);
    b0.iWE = 1'b0;
    @(posedge clk);
    #1;
    b0.cs = 1'b0;
    chk("w0_last_ready", {31'b0, b0.ready}, 32'd1);
    chk("w0_last_rd", b0.rdata, 32'h5A5AA5A5);
    @(posedge clk);
    #1;

    @(negedge clk);
    b1.cs       = 1'b1;
    b1.iWE      = 1'b0;
    b1.iAddress = 32'h010;
    @(posedge clk);
    #1;
    b1.cs = 1'b0;
    chk("mid_wait_ready", {31'b0, b1.ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_ready", {31'b0, b1.ready}, 32'd0);
    chk("async_err", {31'b0, b1.err}, 32'd0);
    chk("async_rdata", b1.rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req1(1'b0, 32'h010, 32'h0, 4'h0, rd, er, lat);
    chk("post_rst_lat", lat, 32'd1);
    chk("post_rst_rd", rd, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
